// File: rtl/demux_param_one_hot_reg_pkg.sv
// Shared constants and helpers for the one-hot registered 1-to-4 demultiplexer.
package demux_param_one_hot_reg_pkg;

   localparam int         NUM_CH   = 4;
   localparam logic [3:0] SEL_A    = 4'b0001;
   localparam logic [3:0] SEL_B    = 4'b0010;
   localparam logic [3:0] SEL_C    = 4'b0100;
   localparam logic [3:0] SEL_D    = 4'b1000;
   localparam logic [3:0] SEL_NONE = 4'b0000;

   function automatic logic is_one_hot4(input logic [3:0] sel);
      logic [2:0] ones;
      ones = 3'd0;
      for (int i = 0; i < 4; i++) begin
         ones = ones + {2'b00, sel[i]};
      end
      return (ones == 3'd1);
   endfunction

endpackage

// File: rtl/demux_param_one_hot_reg_slot.sv
// One-entry channel holding register: load wins over drain so a channel can refill while draining.
module demux_slot_reg
   import demux_param_one_hot_reg_pkg::*;
#(
   parameter int LENGTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              drain,
   input  logic [LENGTH-1:0] d,
   output logic [LENGTH-1:0] q,
   output logic              valid
);

   logic [LENGTH-1:0] data_q;
   logic [LENGTH-1:0] data_d;
   logic              valid_q;
   logic              valid_d;

   // Next-state for the held word and its valid flag; data is kept after a drain.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (load) begin
         data_d  = d;
         valid_d = 1'b1;
      end else if (drain) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Channel state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= {LENGTH{1'b0}};
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign q     = data_q;
   assign valid = valid_q;

endmodule

// File: rtl/demux_param_one_hot_reg.sv
// Registered 1-to-4 one-hot demultiplexer with per-channel holding registers and
// a flagged, saturating count of illegal selects (which are consumed and dropped).
module demux_param_one_hot_reg
   import demux_param_one_hot_reg_pkg::*;
#(
   parameter int LENGTH    = 32,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [LENGTH-1:0]    i_data,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [3:0]           i_selector,
   output logic [LENGTH-1:0]    o_a,
   output logic [LENGTH-1:0]    o_b,
   output logic [LENGTH-1:0]    o_c,
   output logic [LENGTH-1:0]    o_d,
   output logic [3:0]           o_valid,
   input  logic [3:0]           i_ready,
   output logic                 o_sel_err,
   output logic [ERR_CNT_W-1:0] o_err_count
);

   logic                 legal_s;
   logic                 ready_s;
   logic                 accept_s;
   logic [3:0]           load_s;
   logic [3:0]           drain_s;
   logic [3:0]           valid_s;
   logic [LENGTH-1:0]    ch_data_s [NUM_CH];
   logic                 sel_err_q;
   logic                 sel_err_d;
   logic [ERR_CNT_W-1:0] err_count_q;
   logic [ERR_CNT_W-1:0] err_count_d;

   assign legal_s = is_one_hot4(i_selector);

   // Ready mux: a legal select waits only on its own channel; illegal words are always taken.
   always_comb begin
      ready_s = 1'b1;
      if (legal_s) begin
         ready_s = ~|(valid_s & ~i_ready & i_selector);
      end else begin
         ready_s = 1'b1;
      end
   end

   assign accept_s = i_valid & ready_s;
   assign load_s   = (accept_s & legal_s) ? i_selector : 4'b0000;
   assign drain_s  = valid_s & i_ready;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
      demux_slot_reg #(.LENGTH(LENGTH)) u_slot (
         .clk   (clk),
         .rst   (rst),
         .load  (load_s[g]),
         .drain (drain_s[g]),
         .d     (i_data),
         .q     (ch_data_s[g]),
         .valid (valid_s[g])
      );
   end

   // Error pulse and saturating illegal-select counter next-state.
   always_comb begin
      sel_err_d   = accept_s & ~legal_s;
      err_count_d = err_count_q;
      if (sel_err_d && (err_count_q != {ERR_CNT_W{1'b1}})) begin
         err_count_d = err_count_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end else begin
         err_count_d = err_count_q;
      end
   end

   // Error state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_err_q   <= 1'b0;
         err_count_q <= {ERR_CNT_W{1'b0}};
      end else begin
         sel_err_q   <= sel_err_d;
         err_count_q <= err_count_d;
      end
   end

   assign o_ready     = ready_s;
   assign o_valid     = valid_s;
   assign o_a         = ch_data_s[0];
   assign o_b         = ch_data_s[1];
   assign o_c         = ch_data_s[2];
   assign o_d         = ch_data_s[3];
   assign o_sel_err   = sel_err_q;
   assign o_err_count = err_count_q;

endmodule

// File: tb/tb_demux_param_one_hot_reg.sv
// Directed scoreboard bench: two instances (default and 2-bit error counter) share one stimulus.
module tb_demux_param_one_hot_reg;
   import demux_param_one_hot_reg_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_data;
   logic        i_valid;
   logic [3:0]  i_selector;
   logic [3:0]  i_ready;

   logic        o_ready, o_sel_err;
   logic [31:0] o_a, o_b, o_c, o_d;
   logic [3:0]  o_valid;
   logic [7:0]  o_err_count;

   logic        s_ready, s_sel_err;
   logic [31:0] s_a, s_b, s_c, s_d;
   logic [3:0]  s_valid;
   logic [1:0]  s_err_count;

   logic [31:0] sb [4][$];
   int          cnt8;
   int          cnt2;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   demux_param_one_hot_reg dut (
      .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
      .i_selector(i_selector), .o_a(o_a), .o_b(o_b), .o_c(o_c), .o_d(o_d),
      .o_valid(o_valid), .i_ready(i_ready), .o_sel_err(o_sel_err), .o_err_count(o_err_count)
   );

   demux_param_one_hot_reg #(.LENGTH(32), .ERR_CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(s_ready),
      .i_selector(i_selector), .o_a(s_a), .o_b(s_b), .o_c(s_c), .o_d(s_d),
      .o_valid(s_valid), .i_ready(i_ready), .o_sel_err(s_sel_err), .o_err_count(s_err_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ch_data(input int k);
      case (k)
         0:       return o_a;
         1:       return o_b;
         2:       return o_c;
         default: return o_d;
      endcase
   endfunction

   function automatic logic [3:0] model_valid();
      logic [3:0] v;
      for (int k = 0; k < 4; k++) v[k] = (sb[k].size() != 0);
      return v;
   endfunction

   // One clock of stimulus: check ready and drained words before the edge, state after it.
   task automatic step(input logic [31:0] d, input logic v, input logic [3:0] sel, input logic [3:0] rdy);
      logic       legal, exp_rdy, acc, exp_err;
      logic [3:0] mv;
      @(negedge clk);
      i_data = d; i_valid = v; i_selector = sel; i_ready = rdy;
      #1;
      legal   = ($countones(sel) == 1);
      mv      = model_valid();
      exp_rdy = 1'b1;
      for (int k = 0; k < 4; k++) if (legal && sel[k]) exp_rdy = !mv[k] || rdy[k];
      chk("o_ready", o_ready, exp_rdy);
      chk("sat_o_ready", s_ready, exp_rdy);
      acc = v && exp_rdy;
      for (int k = 0; k < 4; k++) begin
         if (mv[k] && rdy[k]) begin
            chk($sformatf("drain_data_ch%0d", k), ch_data(k), sb[k][0]);
            void'(sb[k].pop_front());
         end
      end
      for (int k = 0; k < 4; k++) if (acc && legal && sel[k]) sb[k].push_back(d);
      exp_err = acc && !legal;
      if (exp_err) begin
         if (cnt8 < 255) cnt8++;
         if (cnt2 < 3) cnt2++;
      end
      @(posedge clk);
      #1;
      chk("o_valid", o_valid, model_valid());
      chk("sat_o_valid", s_valid, model_valid());
      chk("o_sel_err", o_sel_err, exp_err);
      chk("sat_o_sel_err", s_sel_err, exp_err);
      chk("o_err_count", o_err_count, cnt8);
      chk("sat_o_err_count", s_err_count, cnt2);
      for (int k = 0; k < 4; k++)
         if (sb[k].size() != 0) chk($sformatf("held_data_ch%0d", k), ch_data(k), sb[k][0]);
   endtask

   initial begin
      cnt8 = 0; cnt2 = 0;
      // Reset held with a pending legal word on the input.
      rst = 1'b1; i_valid = 1'b1; i_selector = SEL_B; i_ready = 4'b0000; i_data = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_o_valid", o_valid, 4'b0000);
      chk("rst_o_ready", o_ready, 1'b1);
      chk("rst_o_sel_err", o_sel_err, 1'b0);
      chk("rst_o_err_count", o_err_count, 8'd0);
      for (int k = 0; k < 4; k++) chk($sformatf("rst_data_ch%0d", k), ch_data(k), 32'd0);
      rst = 1'b0; i_valid = 1'b0;

      // Routing to each channel.
      step(32'hA1, 1'b1, SEL_A, 4'b1111);
      step(32'hB2, 1'b1, SEL_B, 4'b1111);
      step(32'hC3, 1'b1, SEL_C, 4'b1111);
      step(32'hD4, 1'b1, SEL_D, 4'b1111);
      step(32'h0, 1'b0, SEL_NONE, 4'b1111);

      // Stall then drain-and-refill on channel b.
      step(32'h11, 1'b1, SEL_B, 4'b1101);
      step(32'h22, 1'b1, SEL_B, 4'b1101);
      chk("stall_ch_b", o_b, 32'h11);
      step(32'h22, 1'b1, SEL_B, 4'b1111);
      step(32'h0, 1'b0, SEL_NONE, 4'b1111);

      // Channel c stalled full while a/b/d stream.
      step(32'h33, 1'b1, SEL_C, 4'b1011);
      for (int i = 0; i < 12; i++)
         step(32'h100 + i, 1'b1, (i < 4) ? SEL_A : ((i < 8) ? SEL_B : SEL_D), 4'b1011);
      chk("indep_ch_c", o_c, 32'h33);
      step(32'h0, 1'b0, SEL_NONE, 4'b1111);

      // i_valid low: no state change regardless of select or data.
      step($urandom, 1'b0, 4'b0011, 4'b0000);
      step($urandom, 1'b0, SEL_A, 4'b0000);

      // Back-to-back illegal selects.
      step(32'hE0, 1'b1, 4'b0000, 4'b1111);
      step(32'hE1, 1'b1, 4'b0011, 4'b1111);
      step(32'hE2, 1'b1, 4'b1111, 4'b1111);
      chk("illegal_count3", o_err_count, 8'd3);
      step(32'h0, 1'b0, SEL_NONE, 4'b1111);

      // Async reset between edges with channels full.
      step(32'hF1, 1'b1, SEL_A, 4'b0000);
      step(32'hF3, 1'b1, SEL_C, 4'b0000);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_o_valid", o_valid, 4'b0000);
      chk("async_sat_o_valid", s_valid, 4'b0000);
      chk("async_o_err_count", o_err_count, 8'd0);
      chk("async_sat_err_count", s_err_count, 2'd0);
      chk("async_ch_a", o_a, 32'd0);
      for (int k = 0; k < 4; k++) sb[k].delete();
      cnt8 = 0; cnt2 = 0;
      @(negedge clk);
      rst = 1'b0;

      // Five illegal selects: narrow counter saturates at 3.
      step(32'h1, 1'b1, 4'b0101, 4'b1111);
      step(32'h2, 1'b1, 4'b0000, 4'b1111);
      step(32'h3, 1'b1, 4'b1100, 4'b1111);
      step(32'h4, 1'b1, 4'b0111, 4'b1111);
      step(32'h5, 1'b1, 4'b1111, 4'b1111);
      chk("sat_count", s_err_count, 2'd3);
      chk("wide_count", o_err_count, 8'd5);
      step(32'h0, 1'b0, SEL_NONE, 4'b1111);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
